// File: rtl/apb_master_ctrl.sv
// ----------------------------------------------------------------------------
// apb_master_ctrl
//
// Turns a simple valid/ready command stream into single APB transfers and
// returns a valid/ready response. Only one transfer is in flight at a time:
// a command is accepted in IDLE, driven as SETUP then ACCESS on the APB bus,
// and its result is held in RESP until the response is consumed. An ACCESS
// phase that sees no pready for TIMEOUT cycles is aborted with an error.
//
// Parameters
//   ADDR_W   address width (paddr, cmd_addr)
//   DATA_W   data width (pwdata, prdata, cmd_wdata, rsp_rdata)
//   TIMEOUT  maximum ACCESS cycles without pready, 2..255
//
// Ports
//   pclk, presetn          clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_write              1 = write, 0 = read
//   cmd_addr, cmd_wdata    transfer address and write data
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata              read data (0 for writes and failed transfers)
//   rsp_err                transfer failed (pslverr or timeout)
//   rsp_timeout            transfer aborted by timeout
//   psel, penable, pwrite  APB requester controls
//   paddr, pwdata          APB address and write data
//   prdata, pready, pslverr APB completer response
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// ----------------------------------------------------------------------------
module apb_master_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    // command side
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response side
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    // APB requester
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // The wait counter holds the number of completed ACCESS cycles that saw
    // pready low; the TIMEOUT-th such cycle is the one that aborts.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic       wait_expired;

    logic       cmd_ready_nxt;
    logic       psel_nxt;
    logic       penable_nxt;
    logic       rsp_valid_nxt;

    assign wait_expired = (wait_cnt == WAIT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so
    // every flop samples the values from before the clock edge.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: next_state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                // cmd_ready is high exactly while in IDLE, so cmd_valid alone
                // completes the handshake here.
                if (cmd_valid) begin
                    next_state = S_SETUP;
                end
            end
            S_SETUP: begin
                next_state = S_ACCESS;
            end
            S_ACCESS: begin
                // pready wins over a timeout firing in the same cycle.
                if (pready || wait_expired) begin
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: decode the state being entered so the control outputs
    // can be registered and change together with the state itself.
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready_nxt = 1'b0;
        psel_nxt      = 1'b0;
        penable_nxt   = 1'b0;
        rsp_valid_nxt = 1'b0;
        case (next_state)
            S_IDLE: begin
                cmd_ready_nxt = 1'b1;
            end
            S_SETUP: begin
                psel_nxt = 1'b1;
            end
            S_ACCESS: begin
                psel_nxt    = 1'b1;
                penable_nxt = 1'b1;
            end
            S_RESP: begin
                rsp_valid_nxt = 1'b1;
            end
            default: begin
                cmd_ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cmd_ready <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            cmd_ready <= cmd_ready_nxt;
            psel      <= psel_nxt;
            penable   <= penable_nxt;
            rsp_valid <= rsp_valid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request datapath: captured once at the command handshake and then
    // left untouched, which keeps paddr/pwrite/pwdata stable through the
    // whole transfer and holding their last value in IDLE and RESP.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
        end else if (state == S_IDLE && cmd_valid) begin
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Wait counter and response capture. Completer inputs are only looked
    // at in ACCESS; the response registers then hold through RESP.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt    <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                S_SETUP: begin
                    // SETUP always precedes ACCESS, so clearing here means the
                    // count starts from zero on every ACCESS entry.
                    wait_cnt <= '0;
                end
                S_ACCESS: begin
                    if (pready) begin
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        // Read data is only meaningful for an error-free read.
                        rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_expired) begin
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_rdata   <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// ----------------------------------------------------------------------------
// tb_apb_master_ctrl
//
// Self-checking bench for apb_master_ctrl. The bench plays both the command
// source and the APB completer. A transaction-level model tracks, for the
// transfer in flight, how many cycles have passed since the command was
// accepted and how long its ACCESS phase must last (completer wait count, or
// TIMEOUT when the completer never answers). Expected bus/response values
// follow from that arithmetic and are compared on every falling edge.
// Directed transfers come first with literal expectations, then random ones.
// ----------------------------------------------------------------------------
module tb_apb_master_ctrl;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              pclk    = 1'b0;
    logic              presetn = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr  = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata  = '0;
    logic              pready  = 1'b0;
    logic              pslverr = 1'b0;

    always #5 pclk = ~pclk;

    apb_master_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requested transfer (set by the stimulus, consumed by the model on accept)
    bit          req_pending = 0;
    bit          req_write   = 0;
    logic [31:0] req_addr    = '0;
    logic [31:0] req_wdata   = '0;
    int          req_wait    = 0;   // pready-low ACCESS cycles before answering
    bit          req_err     = 0;
    int          rsp_hold    = 0;   // RESP cycles with rsp_ready low
    bit          junk_valid  = 0;   // keep cmd_valid high while busy

    // ------------------------------------------------------------------
    // Transaction-level reference model
    // ------------------------------------------------------------------
    bit          m_busy     = 0;
    int          m_age      = 0;    // edges since command accept
    int          m_acc_len  = 1;    // ACCESS cycles this transfer lasts
    int          m_wait     = 0;
    bit          m_err_plan = 0;
    logic [31:0] m_paddr    = '0;
    logic [31:0] m_pwdata   = '0;
    bit          m_pwrite   = 0;
    logic [31:0] m_rdata    = '0;
    bit          m_rsp_err  = 0;
    bit          m_rsp_to   = 0;
    logic [31:0] mem [logic [31:0]];

    initial begin : model
        forever begin
            @(posedge pclk or negedge presetn);
            if (!presetn) begin
                m_busy = 0; m_age = 0; req_pending = 0;
                m_paddr = '0; m_pwdata = '0; m_pwrite = 0;
                m_rdata = '0; m_rsp_err = 0; m_rsp_to = 0;
            end else if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy     = 1;
                    m_age      = 0;
                    m_paddr    = cmd_addr;
                    m_pwdata   = cmd_wdata;
                    m_pwrite   = cmd_write;
                    m_wait     = req_wait;
                    m_err_plan = req_err;
                    m_acc_len  = (req_wait < TIMEOUT) ? req_wait + 1 : TIMEOUT;
                    req_pending = 0;
                end
            end else if (m_age > m_acc_len) begin
                if (rsp_ready) m_busy = 0;
                else           m_age++;
            end else begin
                if (m_age == m_acc_len) begin
                    if (m_wait >= TIMEOUT) begin
                        m_rsp_err = 1; m_rsp_to = 1; m_rdata = '0;
                    end else begin
                        m_rsp_to  = 0;
                        m_rsp_err = pslverr;
                        m_rdata   = (!m_pwrite && !pslverr) ? prdata : '0;
                        if (m_pwrite && !pslverr) mem[m_paddr] = m_pwdata;
                    end
                end
                m_age++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare process: every falling edge outside reset
    // ------------------------------------------------------------------
    int          setup_cnt = 0;
    int          acc_cnt   = 0;
    int          rsp_cnt   = 0;
    bit          cap_valid = 0;
    logic [31:0] cap_rdata = '0;
    bit          cap_err   = 0;
    bit          cap_to    = 0;

    initial begin : compare
        forever begin
            @(negedge pclk);
            if (presetn) begin
                if (psel && !penable) setup_cnt++;
                if (psel && penable)  acc_cnt++;
                if (rsp_valid) begin
                    rsp_cnt++;
                    if (!cap_valid) begin
                        cap_valid = 1; cap_rdata = rsp_rdata;
                        cap_err = rsp_err; cap_to = rsp_timeout;
                    end
                end
                check("cmd_ready", cmd_ready, !m_busy);
                check("psel",      psel,      m_busy && m_age <= m_acc_len);
                check("penable",   penable,   m_busy && m_age >= 1 && m_age <= m_acc_len);
                check("rsp_valid", rsp_valid, m_busy && m_age > m_acc_len);
                check("paddr",     paddr,     m_paddr);
                check("pwdata",    pwdata,    m_pwdata);
                check("pwrite",    pwrite,    m_pwrite);
                if (m_busy && m_age > m_acc_len) begin
                    check("rsp_rdata",   rsp_rdata,   m_rdata);
                    check("rsp_err",     rsp_err,     m_rsp_err);
                    check("rsp_timeout", rsp_timeout, m_rsp_to);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs for the coming edge, derived from the model's view
    // ------------------------------------------------------------------
    task automatic drive_cycle();
        if (!m_busy) begin
            cmd_valid = req_pending;
            cmd_write = req_pending ? req_write : 1'($urandom_range(0, 1));
            cmd_addr  = req_pending ? req_addr  : $urandom;
            cmd_wdata = req_pending ? req_wdata : $urandom;
        end else begin
            cmd_valid = junk_valid ? 1'b1 : 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
        end
        if (m_busy && m_age >= 1 && m_age <= m_acc_len && (m_age - 1) == m_wait) begin
            pready  = 1'b1;
            pslverr = m_err_plan;
            if (!m_err_plan && mem.exists(m_paddr)) prdata = mem[m_paddr];
            else                                    prdata = $urandom;
        end else if (m_busy && m_age >= 1 && m_age <= m_acc_len) begin
            pready  = 1'b0;
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
        end else begin
            // Outside ACCESS the completer lines carry noise.
            pready  = 1'($urandom_range(0, 1));
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
        end
        if (m_busy && m_age > m_acc_len) rsp_ready = ((m_age - m_acc_len - 1) >= rsp_hold);
        else                             rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int wt, input bit err, input int hold, input bit junk);
        bit done;
        req_write = wr; req_addr = addr; req_wdata = wdata;
        req_wait = wt; req_err = err; rsp_hold = hold; junk_valid = junk;
        req_pending = 1;
        setup_cnt = 0; acc_cnt = 0; rsp_cnt = 0; cap_valid = 0;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            drive_cycle();
            @(negedge pclk);
            #1;
            done = !req_pending && !m_busy;
        end
        if (!done) begin
            n_vec++; n_fail++;
            $display("FAIL txn_budget: transfer to %0h did not finish", addr);
        end
    endtask

    initial begin : stimulus
        bit ok;
        // Asynchronous reset, checked before any clock edge.
        #1 presetn = 1'b0;
        #2;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_psel",      psel,      1'b0);
        check("rst_penable",   penable,   1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_paddr",     paddr,     32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge pclk); #1;
        presetn = 1'b1;

        // Zero-wait write: one SETUP, one ACCESS.
        run_txn(1, 32'h4, 32'hDEADBEEF, 0, 0, 0, 0);
        check("wr_setup_cycles",  setup_cnt, 1);
        check("wr_access_cycles", acc_cnt,   1);
        check("wr_rsp_err",       cap_err,   1'b0);
        check("wr_paddr_hold",    paddr,     32'h4);
        check("wr_pwdata_hold",   pwdata,    32'hDEADBEEF);

        // Read back with one wait cycle.
        run_txn(0, 32'h4, 32'h0, 1, 0, 0, 0);
        check("rd_access_cycles", acc_cnt,   2);
        check("rd_rsp_rdata",     cap_rdata, 32'hDEADBEEF);
        check("rd_rsp_err",       cap_err,   1'b0);

        // Read answered with pslverr: data is discarded.
        run_txn(0, 32'h4, 32'h0, 0, 1, 1, 0);
        check("slverr_rsp_err",   cap_err,   1'b1);
        check("slverr_rsp_to",    cap_to,    1'b0);
        check("slverr_rsp_rdata", cap_rdata, 32'h0);

        // Completer never answers: TIMEOUT ACCESS cycles, then abort.
        run_txn(0, 32'h8, 32'h0, 100, 0, 2, 0);
        check("to_access_cycles", acc_cnt,   TIMEOUT);
        check("to_rsp_err",       cap_err,   1'b1);
        check("to_rsp_timeout",   cap_to,    1'b1);
        check("to_rsp_rdata",     cap_rdata, 32'h0);

        // pready on the very cycle the timeout would fire: normal completion.
        run_txn(0, 32'h4, 32'h0, TIMEOUT - 1, 0, 0, 0);
        check("edge_access_cycles", acc_cnt,   TIMEOUT);
        check("edge_rsp_timeout",   cap_to,    1'b0);
        check("edge_rsp_rdata",     cap_rdata, 32'hDEADBEEF);

        // Response stalled 5 cycles with cmd_valid held high.
        run_txn(1, 32'h8, 32'h12345678, 0, 0, 5, 1);
        check("stall_rsp_cycles",   rsp_cnt,   6);
        check("stall_setup_cycles", setup_cnt, 1);

        // Reset pulsed during ACCESS abandons the transfer.
        req_write = 0; req_addr = 32'hC; req_wdata = '0; req_wait = 10;
        req_err = 0; rsp_hold = 0; junk_valid = 0; req_pending = 1;
        rsp_cnt = 0;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            drive_cycle();
            @(negedge pclk); #1;
            ok = m_busy && m_age == 3;
        end
        check("reached_access", ok, 1'b1);
        presetn = 1'b0;
        #1;
        check("arst_psel",      psel,      1'b0);
        check("arst_penable",   penable,   1'b0);
        check("arst_rsp_valid", rsp_valid, 1'b0);
        check("arst_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk); #1;
            drive_cycle();
        end
        presetn = 1'b1;
        check("arst_no_response", rsp_cnt, 0);
        run_txn(0, 32'h8, 32'h0, 0, 0, 0, 0);
        check("post_rst_setup",  setup_cnt, 1);
        check("post_rst_rdata",  cap_rdata, 32'h12345678);

        // Randomized transfers.
        for (int t = 0; t < 200; t++) begin
            int r;
            int wt;
            r = $urandom_range(0, 9);
            if (r < 6)       wt = $urandom_range(0, 3);
            else if (r < 8)  wt = $urandom_range(4, 8);
            else if (r == 8) wt = TIMEOUT - 1;
            else             wt = TIMEOUT + $urandom_range(0, 3);
            run_txn(1'($urandom_range(0, 1)), {28'h0, 2'($urandom_range(0, 3)), 2'b00},
                    $urandom, wt, ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
